fifo_burst_drain: RTL and testbench

//  Read-side controller for the FIFO block. Decides when to drain it: burst on

---
 rtl/fifo_burst_drain.sv | 121 ++++++++++++
 tb/tb_fifo_burst_drain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// Read-side drain controller for a FIFO. It bursts on almost_full/full or after an idle timeout,
// and presents the words on a valid/ready port through a 2-entry skid buffer.
module fifo_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int TO_WIDTH   = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out,
    input  logic                  FIFO_empty,
    input  logic                  FIFO_full,
    input  logic                  FIFO_almost_full,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  burst_active,
    output logic [15:0]           words_sent
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [TO_WIDTH-1:0]   idle_cnt_q, idle_cnt_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [15:0]           words_sent_q, words_sent_d;
    logic                  burst_active_q;
    logic                  pop;
    logic [2:0]            occ_after_pop;
    logic                  tail_idx;

    assign rx_valid      = (buf_cnt_q != 2'd0) & Enable;
    assign pop           = rx_valid & rx_ready;
    // Occupancy the buffer will have once the pending capture lands; pop implies buf_cnt_q >= 1.
    assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_enable   = Reset & Enable & (state_q == ST_BURST) & ~FIFO_empty
                           & (occ_after_pop < 3'd2);

    assign rx_data      = buf_q[0];
    assign burst_active = burst_active_q;
    assign words_sent   = words_sent_q;

    always_comb begin
        buf_d[0]  = buf_q[0];
        buf_d[1]  = buf_q[1];
        tail_idx  = (buf_cnt_q - {1'b0, pop}) != 2'd0;
        buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        // Capture is deliberately independent of Enable so an issued read is never dropped.
        if (inflight_q) begin
            buf_d[tail_idx] = FIFO_data_out;
        end
    end

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        words_sent_d = words_sent_q + {15'd0, pop};
        if (Enable) begin
            case (state_q)
                ST_IDLE: begin
                    idle_cnt_d = FIFO_empty ? '0 : idle_cnt_q + 1'b1;
                    if (FIFO_almost_full | FIFO_full
                        | (~FIFO_empty & (idle_cnt_q == TO_WIDTH'(TIMEOUT)))) begin
                        state_d    = ST_BURST;
                        idle_cnt_d = '0;
                    end
                end
                ST_BURST: begin
                    if (FIFO_empty & ~read_enable) begin
                        state_d    = ST_IDLE;
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            idle_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            buf_cnt_q      <= 2'd0;
            words_sent_q   <= 16'd0;
            burst_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            inflight_q     <= read_enable;
            buf_cnt_q      <= buf_cnt_d;
            words_sent_q   <= words_sent_d;
            burst_active_q <= (state_d == ST_BURST);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (!Reset) begin
                buf_q[gi] <= '0;
            end else begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Randomized bench for fifo_burst_drain: emulates the FIFO with a queue and predicts every
// output each cycle from a queue-based model of the drain rules.
module tb_fifo_burst_drain;

    localparam int DW  = 8;
    localparam int TOW = 4;
    localparam int TO  = 15;
    localparam int CAP = 8;
    localparam int AF  = 6;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic [DW-1:0] FIFO_data_out;
    logic          FIFO_empty;
    logic          FIFO_full;
    logic          FIFO_almost_full;
    logic          read_enable;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          burst_active;
    logic [15:0]   words_sent;

    always #5 clk = ~clk;

    fifo_burst_drain #(.DATA_WIDTH(DW), .TO_WIDTH(TOW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .Enable           (Enable),
        .FIFO_data_out    (FIFO_data_out),
        .FIFO_empty       (FIFO_empty),
        .FIFO_full        (FIFO_full),
        .FIFO_almost_full (FIFO_almost_full),
        .read_enable      (read_enable),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .burst_active     (burst_active),
        .words_sent       (words_sent)
    );

    int checks = 0;
    int errors = 0;

    // Environment FIFO contents and reference model state.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mbuf[$];
    bit            m_burst;
    bit            m_inflight;
    int            m_idle;
    logic [15:0]   m_words;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_burst    = 1'b0;
        m_inflight = 1'b0;
        m_idle     = 0;
        m_words    = 16'd0;
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+3, then advance model and FIFO.
    task automatic step(input bit rst_n, input bit en, input bit rdy, input int npush);
        logic [DW-1:0] dout_now;
        bit            re_now, exp_re, exp_valid, pop, empty_now, full_now, af_now;
        int            occ;
        Reset    = rst_n;
        Enable   = en;
        rx_ready = rdy;
        for (int i = 0; i < npush; i++) begin
            if (fifo_q.size() < CAP) fifo_q.push_back(DW'($urandom));
        end
        FIFO_empty       = (fifo_q.size() == 0);
        FIFO_full        = (fifo_q.size() == CAP);
        FIFO_almost_full = (fifo_q.size() >= AF);
        #2;
        exp_valid = en && (mbuf.size() != 0);
        pop       = exp_valid && rdy;
        occ       = mbuf.size() + int'(m_inflight) - int'(pop);
        exp_re    = rst_n && en && m_burst && !FIFO_empty && (occ < 2);
        chk("read_enable", read_enable, exp_re);
        chk("rx_valid", rx_valid, exp_valid);
        if (exp_valid) chk("rx_data", rx_data, mbuf[0]);
        chk("burst_active", burst_active, m_burst);
        chk("words_sent", words_sent, m_words);
        re_now    = read_enable;
        dout_now  = FIFO_data_out;
        empty_now = FIFO_empty;
        full_now  = FIFO_full;
        af_now    = FIFO_almost_full;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (pop) begin
                $display("xfer #%0d data=%0h", m_words, mbuf[0]);
                void'(mbuf.pop_front());
                m_words = m_words + 16'd1;
            end
            if (m_inflight) mbuf.push_back(dout_now);
            chk("buf_occupancy_le2", mbuf.size() <= 2, 1);
            m_inflight = exp_re;
            if (en) begin
                if (!m_burst) begin
                    if (af_now || full_now || (!empty_now && m_idle == TO)) begin
                        m_burst = 1'b1;
                        m_idle  = 0;
                    end else begin
                        m_idle = empty_now ? 0 : m_idle + 1;
                    end
                end else if (empty_now && !exp_re) begin
                    m_burst = 1'b0;
                    m_idle  = 0;
                end
            end
        end
        // Non-read cycles present junk so an ungated capture would be visible.
        if (re_now && fifo_q.size() > 0) FIFO_data_out = fifo_q.pop_front();
        else                             FIFO_data_out = DW'($urandom);
    endtask

    task automatic run(input int n, input int push_pct, input int rdy_pct,
                       input int en_pct, input int rst_pct);
        for (int c = 0; c < n; c++) begin
            step(!($urandom_range(99) < rst_pct), ($urandom_range(99) < en_pct),
                 ($urandom_range(99) < rdy_pct),
                 ($urandom_range(99) < push_pct) ? int'($urandom_range(2, 1)) : 0);
        end
    endtask

    initial begin
        Reset            = 1'b0;
        Enable           = 1'b1;
        rx_ready         = 1'b0;
        FIFO_data_out    = '0;
        FIFO_empty       = 1'b1;
        FIFO_full        = 1'b0;
        FIFO_almost_full = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held two cycles with a full FIFO.
        step(1'b0, 1'b1, 1'b1, CAP);
        step(1'b0, 1'b1, 1'b1, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_words_sent", words_sent, 0);
        chk("rst_burst_active", burst_active, 0);
        run(30, 0, 100, 100, 0);

        // Almost-full burst of 6, then a lone word that must wait for the timeout.
        step(1'b1, 1'b1, 1'b1, 6);
        run(20, 0, 100, 100, 0);
        step(1'b1, 1'b1, 1'b1, 1);
        run(25, 0, 100, 100, 0);

        // Backpressure during a burst, then release.
        step(1'b1, 1'b1, 1'b0, 6);
        run(10, 0, 0, 100, 0);
        run(15, 0, 100, 100, 0);

        // Enable drop right after the first reads.
        step(1'b1, 1'b1, 1'b1, 6);
        step(1'b1, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 0);
        run(15, 0, 100, 100, 0);

        // Reset with the skid buffer full.
        step(1'b1, 1'b1, 1'b0, 6);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        run(25, 0, 100, 100, 0);

        // Randomized mixes: busy traffic with resets, then sparse traffic exercising timeouts.
        run(3000, 30, 70, 85, 1);
        run(2000, 5, 90, 95, 0);
        run(1000, 60, 40, 90, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
